// File: rtl/refresh_scanner.sv
// refresh_scanner: digit-scan sequencer for multiplexed seven-segment displays
// Ports:
//   clock, reset_n     system clock, synchronous active-low reset
//   enable             scanning runs while high
//   digit_mask         per-digit scan enable (1 = scanned)
//   digit_index        index of the current slot's digit
//   anode_n            active-low one-hot anode enable
//   blank              high whenever no anode is asserted
//   scan_tick          pulse on the first cycle of every slot
//   frame_done         pulse on the first cycle of a slot reached by wrapping
module refresh_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [IDX_W-1:0]      digit_index,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic                  blank,
    output logic                  scan_tick,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx_first, idx_adv, idx_n;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    run_ok, last, show_n;

    // first set mask bit at or after start, searching circularly
    function automatic logic [IDX_W-1:0] find(input int start, input logic [NUM_DIGITS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            if (m[(start + k) % NUM_DIGITS]) r = IDX_W'((start + k) % NUM_DIGITS);
        return r;
    endfunction

    // outputs are registered from the values the next cycle will hold
    always_comb begin
        run_ok    = enable && |digit_mask;
        last      = state == RUN && cnt == LAST;
        idx_first = find(int'(digit_index), digit_mask);
        idx_adv   = find((int'(digit_index) + 1) % NUM_DIGITS, digit_mask);
        idx_n     = state == IDLE ? idx_first : last ? idx_adv : digit_index;
        cnt_n     = state == RUN && !last ? cnt + 1'b1 : '0;
        onehot    = NUM_DIGITS'(1) << idx_n;
        show_n    = cnt_n >= BLANK && digit_mask[idx_n];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_index <= '0;
            anode_n     <= '1;
            blank       <= 1'b1;
            scan_tick   <= 1'b0;
            frame_done  <= 1'b0;
        end else if (!run_ok) begin
            state      <= IDLE;
            cnt        <= '0;
            anode_n    <= '1;
            blank      <= 1'b1;
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state       <= RUN;
            cnt         <= cnt_n;
            digit_index <= idx_n;
            anode_n     <= show_n ? ~onehot : '1;
            blank       <= !show_n;
            scan_tick   <= state == IDLE || last;
            frame_done  <= last && idx_adv <= digit_index;
        end
    end
endmodule

// File: doc/refresh_scanner.md
# refresh_scanner

Parametrised digit-scan sequencer for multiplexed seven-segment displays. It divides the system clock into fixed-length digit slots, walks a digit index across a configurable number of digits, and drives active-low anode enables directly. Compared with a free-running 2-bit refresh counter, it adds:
- a non-power-of-two digit count;
- per-digit skip masking;
- an anti-ghosting blanking interval at the start of each slot;
- enable/hold control;
- slot and frame strobes.

It sits between the top-level clock and the anode/cathode control logic.

## Interface
- NUM_DIGITS, default 4: number of digits scanned (1..8).
- PRESCALE, default 100000: clock cycles per digit slot (>= 2).
- BLANK_CYCLES, default 1000: blanked cycles at the start of each slot (0..PRESCALE-1).
- IDX_W (localparam): max(1, clog2(NUM_DIGITS)).
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  scanning runs while high; low forces the idle/blank state.
- digit_mask  in  NUM_DIGITS  bit i = 1 means digit i is scanned; 0 means it is skipped.
- digit_index  out  IDX_W  index of the current slot's digit (registered).
- anode_n  out  NUM_DIGITS  active-low one-hot anode enable (registered).
- blank  out  1  high whenever no anode is asserted.
- scan_tick  out  1  one-cycle pulse on the first cycle of every slot.
- frame_done  out  1  one-cycle pulse on the first cycle of a slot reached by wrapping.

## Operation
- States:
  - IDLE: not scanning.
  - RUN: scanning; sub-phase BLANK when cnt < BLANK_CYCLES, SHOW otherwise.
- Slot counter cnt runs 0..PRESCALE-1 in RUN and is held at 0 in IDLE.
- IDLE -> RUN when enable=1 and digit_mask != 0.
  - The first slot starts on the next cycle with cnt=0.
  - digit_index becomes the current index if its mask bit is set, otherwise the next set bit searching upward circularly.
- RUN -> IDLE on the cycle after enable=0 or digit_mask==0. digit_index is held and cnt is cleared.
- Advance happens at cnt==PRESCALE-1:
  - next cycle cnt=0;
  - digit_index = next set mask bit strictly after the current one, searching circularly over 0..NUM_DIGITS-1;
  - the index never takes a value >= NUM_DIGITS.
- Wrap: an advance whose new index <= old index (including a single enabled digit advancing to itself) sets frame_done in the new slot's first cycle.
- anode_n[digit_index]=0 only in the SHOW phase and only while digit_mask[digit_index]=1. All other bits are 1 at all times.
- blank = &anode_n.
- Mask changes:
  - sampled every cycle;
  - clearing the current digit's bit mid-slot deasserts its anode from the next cycle;
  - the slot still runs to full length;
  - the new mask governs the next advance.
- BLANK_CYCLES=0: no BLANK phase. The anode asserts on the slot's first cycle.

## Timing
- Reset values (cycle after reset_n sampled low): state IDLE, cnt=0, digit_index=0, anode_n all 1s, blank=1, scan_tick=0, frame_done=0. Reset overrides enable.
- Latency enable rise -> scan_tick: 1 cycle. scan_tick -> first anode assertion: BLANK_CYCLES cycles.
- Slot length is exactly PRESCALE cycles. scan_tick period is PRESCALE cycles while running.
- Anode asserted cycles per slot: PRESCALE-BLANK_CYCLES.
- Frame period is PRESCALE × popcount(digit_mask) cycles when the mask is stable.
- frame_done is never asserted without scan_tick in the same cycle.
- enable fall: anode_n all 1s on the next cycle and no further strobes. A mid-slot re-enable restarts a full slot (cnt=0, scan_tick pulses).
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with enable=1 -> anode_n=4'b1111, digit_index=0, blank=1, no strobes. Release -> scan_tick one cycle later.
- Basic scan, NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, mask=4'b1111 -> per slot: 2 blank cycles then 6 cycles with anode_n=1110, 1101, 1011, 0111 in order. frame_done is seen on the slot returning to index 0, every 32 cycles.
- Non-power-of-two, NUM_DIGITS=3, mask=3'b111 -> index sequence 0,1,2,0, never 3. frame_done every 24 cycles.
- Skip mask 4'b1010 -> indices 1,3,1,3. frame_done on each return to 1. Set mask=4'b0010 mid-slot on digit 3 -> digit 3's anode goes high the next cycle. After the slot ends, only digit 1 is scanned, with frame_done on every slot.
- enable low mid-SHOW -> all anodes high the next cycle and digit_index held. Re-enable -> scan_tick after 1 cycle, then a full 8-cycle slot on the same digit.
- mask=0 with enable=1 -> stays IDLE and blank=1. BLANK_CYCLES=0 -> the anode asserts in the same cycle as scan_tick.
